// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA timing generator, single clock domain.
//
// The pixel rate is derived from Clk by an integer divider; pix_en is the
// resulting one-Clk-per-pixel clock enable and every other register only
// advances on Clk edges where pix_en is high.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous, active-low reset
//   pix_en       out  pixel clock enable (held at 1 when CLK_DIV = 1)
//   hs, vs       out  horizontal / vertical sync, active at HS_POL / VS_POL
//   blank        out  1 = display, 0 = blanked (DAC BLANK_N polarity)
//   sync         out  composite sync, constant 0
//   DrawX, DrawY out  horizontal / vertical counters, CW bits
//   line_start   out  one-Clk pulse after DrawX wraps to 0
//   frame_start  out  one-Clk pulse after DrawX and DrawY both wrap to 0
//   frame_clk    out  toggles once per frame
//   test_rgb     out  colour-bar test pattern, 24 bits
//
// hs, vs, blank (and test_rgb) pass through PIPE_DELAY extra pixel-tick
// register stages; DrawX/DrawY, line_start and frame_start are not delayed.
//
// Optional feature macro: VGA_TIMING_TESTPAT_EN. When defined, test_rgb
// carries eight vertical colour bars; when undefined it is constant 0.
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 0,
    parameter int CW         = 11
) (
    input  logic          Clk,
    input  logic          Reset,
    output logic          pix_en,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start,
    output logic          frame_clk,
    output logic [23:0]   test_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // CLK_DIV is at most 16, so the divider never needs more than 4 bits.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]    div_cnt;
    logic [CW-1:0] hc, vc;
    logic [CW-1:0] hc_nxt, vc_nxt;
    logic          h_wrap, v_wrap;
    logic          hs_dec, vs_dec, disp_dec;

    // Stage 0 is the lookahead decode register; stage PIPE_DELAY drives
    // the outputs.
    logic [PIPE_DELAY:0] hs_pipe, vs_pipe, blank_pipe;

    // ------------------------------------------------------------------
    // Pixel clock enable. Combinational from the divider so that with
    // CLK_DIV = 1 it is already high while Reset holds the count at 0.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    assign pix_en = (div_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Counter next values. The decode below looks at these rather than
    // at hc/vc so the registered syncs line up with DrawX/DrawY.
    // ------------------------------------------------------------------
    always_comb begin
        h_wrap = (hc == H_LAST);
        v_wrap = (vc == V_LAST);
        hc_nxt = h_wrap ? '0 : hc + 1'b1;
        vc_nxt = vc;
        if (h_wrap) begin
            vc_nxt = v_wrap ? '0 : vc + 1'b1;
        end
    end

    always_comb begin
        hs_dec   = ~HS_POL;
        vs_dec   = ~VS_POL;
        disp_dec = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
        if (hc_nxt >= HS_START && hc_nxt < HS_END) begin
            hs_dec = HS_POL;
        end
        if (vc_nxt >= VS_START && vc_nxt < VS_END) begin
            vs_dec = VS_POL;
        end
    end

    // ------------------------------------------------------------------
    // Counters, frame toggle and the undelayed start pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_clk   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Pulses last exactly one Clk cycle, even when pix_en stays high.
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hc <= hc_nxt;
                vc <= vc_nxt;
                if (h_wrap && v_wrap) begin
                    frame_clk <= ~frame_clk;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sync/blank delay line. Reset fills every stage with "blanked, syncs
    // inactive", so no partial sync pulse escapes after a reset.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hs_pipe    <= {(PIPE_DELAY + 1){~HS_POL}};
            vs_pipe    <= {(PIPE_DELAY + 1){~VS_POL}};
            blank_pipe <= '0;
        end else if (pix_en) begin
            for (int i = PIPE_DELAY; i > 0; i--) begin
                hs_pipe[i]    <= hs_pipe[i-1];
                vs_pipe[i]    <= vs_pipe[i-1];
                blank_pipe[i] <= blank_pipe[i-1];
            end
            hs_pipe[0]    <= hs_dec;
            vs_pipe[0]    <= vs_dec;
            blank_pipe[0] <= disp_dec;
        end
    end

    assign hs    = hs_pipe[PIPE_DELAY];
    assign vs    = vs_pipe[PIPE_DELAY];
    assign blank = blank_pipe[PIPE_DELAY];
    assign sync  = 1'b0;
    assign DrawX = hc;
    assign DrawY = vc;

`ifdef VGA_TIMING_TESTPAT_EN
    // Eight equal-width bars across the active line; the last bar absorbs
    // any remainder when H_ACTIVE is not a multiple of 8.
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [CW-1:0] bar_idx;
    logic [23:0]   rgb_dec;
    logic [23:0]   rgb_pipe [PIPE_DELAY+1];

    always_comb begin
        bar_idx = hc_nxt / CW'(BAR_W);
        rgb_dec = 24'h000000;
        if (disp_dec) begin
            case (bar_idx)
                CW'(0):  rgb_dec = 24'hFFFFFF; // white
                CW'(1):  rgb_dec = 24'hFFFF00; // yellow
                CW'(2):  rgb_dec = 24'h00FFFF; // cyan
                CW'(3):  rgb_dec = 24'h00FF00; // green
                CW'(4):  rgb_dec = 24'hFF00FF; // magenta
                CW'(5):  rgb_dec = 24'hFF0000; // red
                CW'(6):  rgb_dec = 24'h0000FF; // blue
                default: rgb_dec = 24'h000000; // black
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                rgb_pipe[i] <= '0;
            end
        end else if (pix_en) begin
            for (int i = PIPE_DELAY; i > 0; i--) begin
                rgb_pipe[i] <= rgb_pipe[i-1];
            end
            rgb_pipe[0] <= rgb_dec;
        end
    end

    // Gate with the delayed blank so the DAC never sees colour off-screen.
    assign test_rgb = blank_pipe[PIPE_DELAY] ? rgb_pipe[PIPE_DELAY] : 24'h000000;
`else
    assign test_rgb = 24'h000000;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller. Generates hs, vs, blank, DrawX and DrawY for any resolution.
- Derives the pixel rate from Clk through an integer divider, so the whole block runs in a single clock domain.
- Delays sync and blank by a configurable number of pixel ticks, so they line up with downstream sprite/ROM pipelines.
- Sits between the system clock and the VGA DAC; replaces the divided pixel clock with a clock enable.

Parameters:
- CLK_DIV, 2: Clk cycles per pixel, 1..16. 50 MHz / 2 = 25 MHz.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: active level of hs.
- VS_POL, 0: active level of vs.
- PIPE_DELAY, 0: pixel ticks of delay applied to hs, vs and blank, 0..7.
- CW, 11: width of DrawX and DrawY. Must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL.

Ports:
- Clk, input, 1: system clock, 50 MHz.
- Reset, input, 1: asynchronous, active-low reset.
- pix_en, output, 1: one-Clk pulse per pixel; the pixel clock enable.
- hs, output, 1: horizontal sync; active at HS_POL.
- vs, output, 1: vertical sync; active at VS_POL.
- blank, output, 1: high = display, low = blanked (same polarity as the DAC BLANK_N).
- sync, output, 1: composite sync; tied to 0.
- DrawX, output, CW: current horizontal counter.
- DrawY, output, CW: current vertical counter.
- line_start, output, 1: one-Clk pulse when DrawX wraps to 0.
- frame_start, output, 1: one-Clk pulse when DrawX and DrawY both wrap to 0.
- frame_clk, output, 1: toggles once per frame.
- test_rgb, output, 24: colour-bar test pattern (see Optional Feature).

Behaviour:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- Divider: counts 0..CLK_DIV-1. pix_en = 1 in the cycle where the count equals CLK_DIV-1. With CLK_DIV=1, pix_en is held at 1 after reset.
- All other state advances only on Clk edges where pix_en = 1.
- Horizontal counter hc: 0..H_TOTAL-1, then wraps to 0. On that wrap, vc increments.
- Vertical counter vc: 0..V_TOTAL-1. When hc and vc wrap together, vc goes to 0 and frame_clk toggles.
- DrawX = hc and DrawY = vc, driven directly from the counter registers.
- Decode, evaluated on the next counter values (lookahead), so registered outputs align with DrawX/DrawY when PIPE_DELAY=0:
  - h-sync active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - v-sync active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - display when hc < H_ACTIVE and vc < V_ACTIVE.
- Delay pipeline: the decoded hs/vs/blank pass through PIPE_DELAY register stages, each clocked by pix_en. Outputs lag DrawX/DrawY by exactly PIPE_DELAY pixel ticks.
- line_start and frame_start are asserted for the single Clk cycle following the wrapping edge. They are not delayed.
- Reset (asynchronous, Reset = 0), all values held while Reset is low:
  - divider = 0, hc = 0, vc = 0.
  - pix_en = 0, except 1 when CLK_DIV = 1.
  - hs = ~HS_POL, vs = ~VS_POL.
  - blank = 0, and every pipeline stage = blanked with syncs inactive.
  - line_start = 0, frame_start = 0, frame_clk = 0, test_rgb = 0.
  - sync is constant 0.
- Consequence of reset state: with PIPE_DELAY=0, the first pixel tick after reset shows blank = 0 even though DrawX = DrawY = 0. The first displayed pixel is (1,0). With PIPE_DELAY=N, the first N+1 pixel ticks are blanked.
- Reset asserted mid-frame: all state is cleared immediately. The first frame after release starts at (0,0); no partial sync pulse is emitted.
- Reset release takes effect at the next Clk edge. The first pix_en follows CLK_DIV cycles later.

Optional Feature:
- Macro: VGA_TIMING_TESTPAT_EN.
- Defined: test_rgb shows eight vertical colour bars, each H_ACTIVE/8 pixels wide. Order: white, yellow, cyan, green, magenta, red, blue, black; each channel is 8'hFF or 8'h00. The output is registered and delayed through the same PIPE_DELAY stages as blank. It is forced to 0 whenever the delayed blank = 0.
- Undefined: test_rgb is a constant 0, and no bar logic is synthesised.

Test Plan:
- Default parameters, run 2 frames → hs low for 96 pixels per line, starting at DrawX=656. vs low on lines 490-491. frame_start period = 800*525*2 Clk cycles. frame_clk toggles twice.
- CLK_DIV=3, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 → pix_en every 3 cycles. hs active for DrawX 10-11. blank = 1 only when DrawX<8 and DrawY<4. 98 pix_en pulses per frame.
- Same small config with PIPE_DELAY=3 → the hs/vs/blank sequence equals the PIPE_DELAY=0 sequence shifted by exactly 3 pix_en ticks. DrawX/DrawY are unchanged.
- Assert Reset at DrawX=5, DrawY=2 for 4 Clk cycles → every output is at its reset value within the same cycle. After release, DrawX counts 0,1,2…; the first frame_start comes after one full frame.
- HS_POL=1, VS_POL=1 → hs and vs idle low and pulse high with the same timing.
- VGA_TIMING_TESTPAT_EN defined, default timing → pixel (0,0) = 24'hFFFFFF, (80,0) = 24'hFFFF00, (639,0) = 24'h000000. Pixel (650,10) = 0 because it is blanked.
